error_check_scheduler: RTL and testbench
========================================

// Module: error_check_scheduler
// PURPOSE
//  Shares one combinational ErrorChecking datapath (DATA_W-bit question -> DATA_W-bit answer) between NUM_REQ requesters.
//  Round-robin arbitration, valid/ready handshakes on both sides, registered question/answer path.
//  Sits between subsystem clients (telemetry, memory scrub, link RX) and the single checker instance.
// PARAMETERS
//  NUM_REQ  2  number of requesters (2..8)
//  DATA_W   4  width of checker question/answer
//  CNT_W    8  width of error counter (ERRCHK_ERR_COUNT_EN only)
// PORTS
//  clk          in   1                clock, rising edge
//  rst_n        in   1                asynchronous, active-low reset
//  req_valid    in   NUM_REQ          per-requester request valid
//  req_data     in   NUM_REQ*DATA_W   question of requester i at [i*DATA_W +: DATA_W]
//  req_ready    out  NUM_REQ          one-hot accept; at most one bit high per cycle
//  chk_question out  DATA_W           registered question to checker
//  chk_answer   in   DATA_W           combinational answer from checker
//  rsp_valid    out  1                response valid
//  rsp_ready    in   1                response consumer ready
//  rsp_id       out  $clog2(NUM_REQ)  index of requester that owns the response
//  rsp_answer   out  DATA_W           captured checker answer
//  rsp_err      out  1                1 when captured answer nonzero (error detected)
//  busy         out  1                1 in any state other than IDLE
//  err_count    out  CNT_W            [ERRCHK_ERR_COUNT_EN] saturating count of rsp_err responses
//  err_clr      in   1                [ERRCHK_ERR_COUNT_EN] synchronous clear of err_count
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0 (chk_question, rsp_*, req_ready, busy, err_count).
//  FSM: IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE : req_ready combinational one-hot to first valid requester scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//          On handshake: chk_question<=req_data[g], id<=g, rr_ptr<=g, goto ISSUE. No valid -> stay.
//   ISSUE: one cycle; chk_question stable; at edge rsp_answer<=chk_answer, rsp_err<=|chk_answer, rsp_valid<=1, goto RESP.
//   RESP : hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_valid&&rsp_ready: rsp_valid<=0, goto IDLE.
//  Latency: accept in cycle N -> rsp_valid high in cycle N+2; throughput one request per 3 cycles max.
//  req_ready low in ISSUE and RESP; requesters must hold req_valid/req_data until accepted.
//  chk_question keeps last value after transaction (no glitching of checker input).
//  rr_ptr updates only on accept; a requester withdrawing valid before grant is not penalised.
//  All requesters valid continuously -> strict rotation 0,1,..,NUM_REQ-1,0.
//  Reset mid-transaction: transaction dropped, no response, rotation restarts at requester 0.
//  rsp_ready high in IDLE/ISSUE ignored. rsp_id width min 1 bit.
// CONFIGURATION
//  ERRCHK_ERR_COUNT_EN defined: err_count increments on each rsp handshake with rsp_err=1, saturates at 2^CNT_W-1;
//   err_clr wins over a simultaneous increment (result 0).
//  Undefined: err_count/err_clr ports absent, no counter logic.
// STRUCTURE
//  Shared package errchk_pkg: FSM state encoding (ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2), default DATA_W.
//  One sub-module: errchk_rr_arbiter (req vector + rr_ptr -> one-hot grant + index), combinational.
//  Checker instance lives outside this block; scheduler only drives/samples its ports.
// TESTING
//  Single req: req_valid=01, req_data[3:0]=4'h5 -> req_ready=01 at N, chk_question=5 at N+1, rsp_valid at N+2, rsp_id=0.
//  Both valid continuously, 6 requests -> grant order 0,1,0,1,0,1; rsp_id matches; no double grant.
//  Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready stays 00, then one handshake returns to IDLE.
//  Error flag: checker model returns 4'h3 -> rsp_err=1; returns 4'h0 -> rsp_err=0; with EN, err_count 1 then unchanged.
//  Saturation (EN, CNT_W=2): 5 error responses -> err_count=3; err_clr coincident with increment -> 0.
//  rst_n low during ISSUE -> rsp_valid=0 immediately, next grant goes to requester 0.

Source files
------------

// File: rtl/errchk_pkg.sv
// errchk_pkg: shared FSM encoding, default widths and id-width helper for the error-check scheduler.
package errchk_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DATA_W  = 4;
  // rsp_id is never narrower than one bit, even for a single requester
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/error_check_scheduler_if.sv
// error_check_scheduler_if: requester-side and response-side handshakes of the error-check scheduler.
interface error_check_scheduler_if #(
  parameter int NUM_REQ = errchk_pkg::DEF_NUM_REQ,
  parameter int DATA_W  = errchk_pkg::DEF_DATA_W
);
  localparam int ID_W = errchk_pkg::id_w(NUM_REQ);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_answer;
  logic                      rsp_err;
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_answer, rsp_err
  );
  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_answer, rsp_err
  );
endinterface

// File: rtl/errchk_rr_arbiter.sv
// errchk_rr_arbiter: combinational round-robin pick, scanning ptr+1, ptr+2, ... modulo NUM_REQ.
module errchk_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [ID_W-1:0] j;
  // farthest offset first, so the nearest valid requester after ptr overrides
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/error_check_scheduler.sv
// error_check_scheduler: round-robin sharing of one combinational checker, registered question/answer path.
// Optional saturating error counter enabled by defining ERRCHK_ERR_COUNT_EN.
module error_check_scheduler
  import errchk_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
`ifdef ERRCHK_ERR_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  error_check_scheduler_if.slave     bus,
  output logic [DATA_W-1:0]          chk_question,
  input  logic [DATA_W-1:0]          chk_answer,
  output logic                       busy
`ifdef ERRCHK_ERR_COUNT_EN
  , output logic [CNT_W-1:0]         err_count,
  input  logic                       err_clr
`endif
);
  localparam int ID_W = id_w(NUM_REQ);
  state_t             state, state_nx;
  logic [ID_W-1:0]    rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any, accept, rsp_hs;

  errchk_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign accept = state == ST_IDLE && gnt_any;
  assign rsp_hs = state == ST_RESP && bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;

  always_comb
    state_nx = state == ST_IDLE  ? (gnt_any ? ST_ISSUE : ST_IDLE) :
               state == ST_ISSUE ? ST_RESP :
               state == ST_RESP  ? (bus.rsp_ready ? ST_IDLE : ST_RESP) : ST_IDLE;

  // grant is masked while reset is held so no requester sees a spurious accept
  always_comb begin
    busy          = state != ST_IDLE;
    bus.req_ready = (state == ST_IDLE && rst_n) ? gnt : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chk_question   <= '0;
      rr_ptr         <= ID_W'(NUM_REQ - 1);
      bus.rsp_id     <= '0;
      bus.rsp_answer <= '0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_valid  <= 1'b0;
    end else begin
      if (accept) begin
        chk_question <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
        bus.rsp_id   <= gnt_idx;
        rr_ptr       <= gnt_idx;
      end
      if (state == ST_ISSUE) begin
        bus.rsp_answer <= chk_answer;
        bus.rsp_err    <= |chk_answer;
        bus.rsp_valid  <= 1'b1;
      end
      if (rsp_hs) bus.rsp_valid <= 1'b0;
    end

`ifdef ERRCHK_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                            err_count <= '0;
    else if (err_clr)                                      err_count <= '0;
    else if (rsp_hs && bus.rsp_err && err_count != '1)     err_count <= err_count + 1'b1;
`endif
endmodule

// File: tb/tb_error_check_scheduler.sv
// tb_error_check_scheduler: table-driven transactions plus backpressure, reset-in-ISSUE and counter sequences.
module tb_error_check_scheduler;
  localparam int NR = 2;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  error_check_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
  logic [DW-1:0] chk_question, chk_answer;
  logic busy;
  // checker stand-in: answer zero only for question 5
  assign chk_answer = chk_question - 4'h5;
`ifdef ERRCHK_ERR_COUNT_EN
  logic [1:0] err_count;
  logic err_clr = 1'b0;
  int exp_cnt = 0;
`endif

  error_check_scheduler #(.NUM_REQ(NR), .DATA_W(DW)
`ifdef ERRCHK_ERR_COUNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .chk_question (chk_question),
    .chk_answer   (chk_answer),
    .busy         (busy)
`ifdef ERRCHK_ERR_COUNT_EN
    , .err_count  (err_count),
    .err_clr      (err_clr)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [3:0] d0, d1;
    logic [1:0] gnt;
    logic       id;
    logic [3:0] q, ans;
    logic       err;
  } vec_t;
  vec_t tbl[8];

  task automatic count_err(input logic e);
`ifdef ERRCHK_ERR_COUNT_EN
    if (e && exp_cnt < 3) exp_cnt++;
`endif
  endtask

  task automatic check_cnt(input string name);
`ifdef ERRCHK_ERR_COUNT_EN
    chk(name, err_count, exp_cnt);
`endif
  endtask

  // entered just after a negedge with the DUT idle; returns just after a negedge, idle again
  task automatic run(input vec_t v, input int n);
    bus.req_valid = v.valid;
    bus.req_data  = {v.d1, v.d0};
    bus.rsp_ready = 1'b0;
    #1;
    chk($sformatf("v%0d req_ready", n), bus.req_ready, v.gnt);
    chk($sformatf("v%0d idle_busy", n), busy, 0);
    @(negedge clk);
    chk($sformatf("v%0d question", n), chk_question, v.q);
    chk($sformatf("v%0d issue_ready", n), bus.req_ready, 0);
    chk($sformatf("v%0d issue_valid", n), bus.rsp_valid, 0);
    chk($sformatf("v%0d issue_busy", n), busy, 1);
    @(negedge clk);
    chk($sformatf("v%0d rsp_valid", n), bus.rsp_valid, 1);
    chk($sformatf("v%0d rsp_id", n), bus.rsp_id, v.id);
    chk($sformatf("v%0d rsp_answer", n), bus.rsp_answer, v.ans);
    chk($sformatf("v%0d rsp_err", n), bus.rsp_err, v.err);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    count_err(v.err);
    chk($sformatf("v%0d done_valid", n), bus.rsp_valid, 0);
    chk($sformatf("v%0d done_busy", n), busy, 0);
    check_cnt($sformatf("v%0d err_count", n));
  endtask

  initial begin
    tbl[0] = '{2'b01, 4'h5, 4'h9, 2'b01, 1'b0, 4'h5, 4'h0, 1'b0};
    tbl[1] = '{2'b11, 4'h8, 4'h2, 2'b10, 1'b1, 4'h2, 4'hD, 1'b1};
    tbl[2] = '{2'b11, 4'h8, 4'h2, 2'b01, 1'b0, 4'h8, 4'h3, 1'b1};
    tbl[3] = '{2'b11, 4'h8, 4'h2, 2'b10, 1'b1, 4'h2, 4'hD, 1'b1};
    tbl[4] = '{2'b11, 4'h8, 4'h2, 2'b01, 1'b0, 4'h8, 4'h3, 1'b1};
    tbl[5] = '{2'b11, 4'h8, 4'h2, 2'b10, 1'b1, 4'h2, 4'hD, 1'b1};
    tbl[6] = '{2'b10, 4'h8, 4'h5, 2'b10, 1'b1, 4'h5, 4'h0, 1'b0};
    tbl[7] = '{2'b10, 4'h8, 4'hF, 2'b10, 1'b1, 4'hF, 4'hA, 1'b1};

    bus.req_valid = 2'b11;
    bus.req_data  = 8'h58;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst question", chk_question, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_id", bus.rsp_id, 0);
    chk("rst rsp_answer", bus.rsp_answer, 0);
    chk("rst rsp_err", bus.rsp_err, 0);
    chk("rst busy", busy, 0);
    check_cnt("rst err_count");
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle req_ready", bus.req_ready, 0);
    chk("idle busy", busy, 0);

    for (int i = 0; i < 8; i++) run(tbl[i], i);

    // backpressure: response held for five cycles while both requesters wait
    bus.req_valid = 2'b01;
    bus.req_data  = 8'h47;
    #1;
    chk("bp req_ready", bus.req_ready, 2'b01);
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d rsp_valid", i), bus.rsp_valid, 1);
      chk($sformatf("bp%0d rsp_answer", i), bus.rsp_answer, 4'h2);
      chk($sformatf("bp%0d rsp_id", i), bus.rsp_id, 0);
      chk($sformatf("bp%0d req_ready", i), bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    count_err(1'b1);
    chk("bp done_valid", bus.rsp_valid, 0);
    check_cnt("bp err_count");
    #1;
    chk("bp next_grant", bus.req_ready, 2'b10);

    // reset while in ISSUE: transaction dropped, rotation restarts at 0
    @(negedge clk);
    chk("rst_issue busy", busy, 1);
    chk("rst_issue question", chk_question, 4'h4);
    rst_n = 1'b0;
    #1;
    chk("rst_issue rsp_valid", bus.rsp_valid, 0);
    chk("rst_issue busy0", busy, 0);
    chk("rst_issue question0", chk_question, 0);
`ifdef ERRCHK_ERR_COUNT_EN
    exp_cnt = 0;
`endif
    check_cnt("rst_issue err_count");
    @(negedge clk);
    chk("rst_issue held_valid", bus.rsp_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst grant", bus.req_ready, 2'b01);
    @(negedge clk);
    chk("post_rst question", chk_question, 4'h7);
    @(negedge clk);
    chk("post_rst rsp_valid", bus.rsp_valid, 1);
    chk("post_rst rsp_id", bus.rsp_id, 0);
    bus.rsp_ready = 1'b1;
`ifdef ERRCHK_ERR_COUNT_EN
    err_clr = 1'b1;
`endif
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    chk("post_rst done_valid", bus.rsp_valid, 0);
`ifdef ERRCHK_ERR_COUNT_EN
    err_clr = 1'b0;
    chk("clr_wins err_count", err_count, 0);
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) run(tbl[2], 10 + i);
    chk("sat err_count", err_count, 3);
    run(tbl[0], 20);
    chk("no_err err_count", err_count, 3);
`endif
    repeat (2) @(negedge clk);
    chk("final busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
